rst_multicdb: RTL and testbench
===============================

// Module: rst_multicdb
// PURPOSE
//  Parametrised register status table (RST) for the Tomasulo dispatcher. Holds one
//  {pending, tag} entry per architectural register. Successor to the single-CDB RST.
//  Adds N_RD read ports, N_CDB broadcast channels, a flush, an x0 guard and a pending count.
//  Sits between decode/dispatch (rename write, source lookup), the CDB and the register file.
// PARAMETERS
//  NUM_REGS  32   architectural registers; AW = $clog2(NUM_REGS)
//  TAG_W     6    ROB/RS tag width
//  N_RD      2    source-lookup read ports (rs, rt, ...)
//  N_CDB     2    CDB broadcast channels per cycle
// PORTS
//  clk               in   1            clock, all state on rising edge
//  rst               in   1            synchronous, active-low reset
//  wen0_rst          in   1            dispatch rename write enable
//  waddr0_rst        in   AW           destination register to rename
//  wdata0_rst        in   TAG_W+1      {pending, tag} written to entry
//  flush_rst         in   1            mispredict flush: clear every pending bit
//  raddr_rst         in   N_RD*AW      read addresses, port i at [i*AW +: AW]
//  rtag_rst          out  N_RD*TAG_W   tag of addressed entry
//  rvalid_rst        out  N_RD         1 = addressed register pending on rtag
//  cdb_valid         in   N_CDB        channel k broadcasting
//  cdb_tag_rst       in   N_CDB*TAG_W  tag broadcast on channel k
//  rd_regfile_rst    out  N_CDB*AW     register index to update for channel k
//  write_en_regfile  out  N_CDB        1 = regfile writes rd_regfile_rst[k] this cycle
//  busy_count        out  AW+1         registered count of pending entries
// BEHAVIOUR
//  - Reset (rst==0 at posedge): all entries {0,0}; busy_count=0. write_en_regfile and
//    rd_regfile_rst are forced 0 while rst==0. rvalid/rtag then read 0.
//  - Reads: combinational, zero latency, from current table state.
//  - CDB match: channel k matches entry r iff cdb_valid[k] && pending[r] && tag[r]==cdb_tag[k].
//    Matching uses the pre-edge table.
//  - Priority:
//    * Lowest r wins if several entries match. Multiple matches cannot occur when tags are unique.
//    * No match -> write_en_regfile[k]=0, rd=0. This covers a stale tag when the register
//      was renamed again.
//    * Matched entry's pending bit clears at the next edge.
//  - Dispatch write: at the edge, entry[waddr0] <= wdata0 when wen0_rst=1.
//    * waddr0==0 is ignored; x0 is never pending.
//    * pending=0 in wdata0 is an explicit clear.
//  - Same-cycle dispatch to r and CDB match on r's old tag:
//    * Dispatch wins; the entry holds the new tag, pending=1.
//    * write_en_regfile is still asserted for r.
//  - Flush: next edge clears every pending bit (tags are kept).
//    * Flush overrides a same-cycle dispatch.
//    * CDB outputs are still generated in the flush cycle.
//  - busy_count: popcount of pending bits, updated at the same edge as the table.
//    Value is 0..NUM_REGS-1.
//  - Two CDB channels carrying the same tag in one cycle are illegal.
//    Under that condition only the lower channel is guaranteed to assert write_en.
// CONFIGURATION
//  RST_CDB_BYPASS_EN defined:
//    * A read port whose entry matches any valid CDB channel this cycle returns rvalid=0.
//      rtag is unchanged. This removes the one-cycle bubble after broadcast.
//    * A same-cycle dispatch write is not bypassed to reads.
//  Undefined: reads show table state only; the cleared pending bit appears one cycle after broadcast.
// TESTING
//  1 Reset 3 cycles, rst=0 -> all rvalid=0, busy_count=0, write_en_regfile=0.
//  2 Dispatch r3<={1,5}; read port0 addr 3 next cycle -> rvalid=1, rtag=5, busy_count=1.
//  3 Dispatch to r3; next cycle cdb ch1 tag=5 -> write_en_regfile=2'b10, rd_regfile ch1=3.
//    Following cycle r3 rvalid=0 and busy_count=0.
//    With RST_CDB_BYPASS_EN, rvalid=0 already in the broadcast cycle.
//  4 r4 pending tag 7, r9 pending tag 8; ch0 tag 7 and ch1 tag 8 in one cycle.
//    -> both write_en=1, rd=4/9; both entries cleared next cycle.
//  5 r6 pending tag 2; redispatch r6<={1,11} while CDB tag 2 broadcasts.
//    -> write_en=1 for r6; next cycle r6 rvalid=1, rtag=11.
//  6 Pending r1,r2; dispatch r0<={1,3}, then flush with dispatch r5 the same cycle.
//    -> r0 never pending; after flush all rvalid=0, busy_count=0.

Source files
------------

// File: rtl/rst_multicdb.sv
// Register status table with N_RD lookup ports, N_CDB broadcast channels, flush and pending count.
// Optional RST_CDB_BYPASS_EN: reads see a same-cycle CDB clear (rvalid drops in the broadcast cycle).
module rst_multicdb #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned TAG_W    = 6,
  parameter int unsigned N_RD     = 2,
  parameter int unsigned N_CDB    = 2,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wen0_rst,
  input  logic [AW-1:0]          waddr0_rst,
  input  logic [TAG_W:0]         wdata0_rst,
  input  logic                   flush_rst,
  input  logic [N_RD*AW-1:0]     raddr_rst,
  output logic [N_RD*TAG_W-1:0]  rtag_rst,
  output logic [N_RD-1:0]        rvalid_rst,
  input  logic [N_CDB-1:0]       cdb_valid,
  input  logic [N_CDB*TAG_W-1:0] cdb_tag_rst,
  output logic [N_CDB*AW-1:0]    rd_regfile_rst,
  output logic [N_CDB-1:0]       write_en_regfile,
  output logic [AW:0]            busy_count
);

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [TAG_W-1:0]    tag_q [NUM_REGS];
  logic [TAG_W-1:0]    tag_d [NUM_REGS];
  logic [AW:0]         busy_q, busy_d;
  // Entries matched by at least one valid channel this cycle
  logic [NUM_REGS-1:0] hit;
  logic [AW-1:0]       ra [N_RD];

  function automatic logic in_range(logic [AW-1:0] a);
    return 32'(a) < NUM_REGS;
  endfunction

  // CDB match; descending scan so the lowest matching entry is reported last
  always_comb begin
    hit              = '0;
    write_en_regfile = '0;
    rd_regfile_rst   = '0;
    for (int k = 0; k < N_CDB; k++) begin
      for (int r = NUM_REGS - 1; r >= 0; r--) begin
        if (cdb_valid[k] && pend_q[r] && (tag_q[r] == cdb_tag_rst[k*TAG_W +: TAG_W])) begin
          hit[r]                      = 1'b1;
          write_en_regfile[k]         = rst;
          rd_regfile_rst[k*AW +: AW]  = rst ? AW'(r) : '0;
        end
      end
    end
  end

  always_comb begin
    pend_d = pend_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      tag_d[r] = tag_q[r];
    end
    if (flush_rst) begin
      pend_d = '0;
    end else begin
      pend_d = pend_q & ~hit;
      // Dispatch is applied after the CDB clear so a redispatch keeps its new pending bit
      if (wen0_rst && (waddr0_rst != '0) && in_range(waddr0_rst)) begin
        pend_d[waddr0_rst] = wdata0_rst[TAG_W];
        tag_d[waddr0_rst]  = wdata0_rst[TAG_W-1:0];
      end
    end
    busy_d = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_d = busy_d + (AW+1)'(pend_d[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q <= '0;
      busy_q <= '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        tag_q[r] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      busy_q <= busy_d;
      for (int r = 0; r < NUM_REGS; r++) begin
        tag_q[r] <= tag_d[r];
      end
    end
  end

  always_comb begin
    rtag_rst   = '0;
    rvalid_rst = '0;
    for (int i = 0; i < N_RD; i++) begin
      ra[i] = raddr_rst[i*AW +: AW];
      if (in_range(ra[i])) begin
        rtag_rst[i*TAG_W +: TAG_W] = tag_q[ra[i]];
`ifdef RST_CDB_BYPASS_EN
        rvalid_rst[i] = pend_q[ra[i]] & ~hit[ra[i]];
`else
        rvalid_rst[i] = pend_q[ra[i]];
`endif
      end
    end
  end

  assign busy_count = busy_q;

endmodule

// File: tb/tb_rst_multicdb.sv
// Scoreboard bench for rst_multicdb: directed scenarios then a randomised phase against a model.
module tb_rst_multicdb;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen0_rst;
  logic [4:0]  waddr0_rst;
  logic [6:0]  wdata0_rst;
  logic        flush_rst;
  logic [9:0]  raddr_rst;
  logic [11:0] rtag_rst;
  logic [1:0]  rvalid_rst;
  logic [1:0]  cdb_valid;
  logic [11:0] cdb_tag_rst;
  logic [9:0]  rd_regfile_rst;
  logic [1:0]  write_en_regfile;
  logic [5:0]  busy_count;

  int n_checks = 0;
  int n_errors = 0;

  string       exp_tag_q [$];
  int          exp_sel_q [$];
  logic [31:0] exp_val_q [$];

  bit          m_pend [32];
  logic [5:0]  m_tag  [32];

  rst_multicdb dut (
    .clk              (clk),
    .rst              (rst),
    .wen0_rst         (wen0_rst),
    .waddr0_rst       (waddr0_rst),
    .wdata0_rst       (wdata0_rst),
    .flush_rst        (flush_rst),
    .raddr_rst        (raddr_rst),
    .rtag_rst         (rtag_rst),
    .rvalid_rst       (rvalid_rst),
    .cdb_valid        (cdb_valid),
    .cdb_tag_rst      (cdb_tag_rst),
    .rd_regfile_rst   (rd_regfile_rst),
    .write_en_regfile (write_en_regfile),
    .busy_count       (busy_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs_val(int sel);
    case (sel)
      0:       return {30'd0, rvalid_rst};
      1:       return {26'd0, rtag_rst[5:0]};
      2:       return {26'd0, rtag_rst[11:6]};
      3:       return {30'd0, write_en_regfile};
      4:       return {22'd0, rd_regfile_rst};
      5:       return {26'd0, busy_count};
      default: return {20'd0, rtag_rst};
    endcase
  endfunction

  task automatic push(string tag, int sel, logic [31:0] val);
    exp_tag_q.push_back(tag);
    exp_sel_q.push_back(sel);
    exp_val_q.push_back(val);
  endtask

  // Compare every queued expectation at the falling edge, then advance past the next rising edge
  task automatic cyc();
    @(negedge clk);
    while (exp_sel_q.size() > 0) begin
      check(exp_tag_q.pop_front(), obs_val(exp_sel_q.pop_front()), exp_val_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen0_rst    = 1'b0;
    waddr0_rst  = '0;
    wdata0_rst  = '0;
    flush_rst   = 1'b0;
    raddr_rst   = '0;
    cdb_valid   = '0;
    cdb_tag_rst = '0;
  endtask

  task automatic disp(int a, bit p, int t);
    wen0_rst   = 1'b1;
    waddr0_rst = 5'(a);
    wdata0_rst = {p, 6'(t)};
  endtask

  task automatic bcast(int k, int t);
    cdb_valid[k]          = 1'b1;
    cdb_tag_rst[k*6 +: 6] = 6'(t);
  endtask

  task automatic raddr(int i, int a);
    raddr_rst[i*5 +: 5] = 5'(a);
  endtask

  task automatic random_phase(int cycles);
    bit          hit [32];
    logic [5:0]  t0, t1, nt;
    logic [1:0]  exp_we, exp_rv;
    logic [9:0]  exp_rd;
    logic [11:0] exp_rt;
    int          busy, a, pr;
    for (int r = 0; r < 32; r++) begin
      m_pend[r] = 1'b0;
      m_tag[r]  = '0;
    end
    for (int c = 0; c < cycles; c++) begin
      idle();
      flush_rst = ($urandom_range(0, 19) == 0);
      // Fresh dispatch tag distinct from every pending tag keeps CDB matches unique
      nt = 6'($urandom_range(0, 63));
      for (int tries = 0; tries < 64; tries++) begin
        bit used = 1'b0;
        for (int r = 0; r < 32; r++) if (m_pend[r] && m_tag[r] == nt) used = 1'b1;
        if (!used) break;
        nt = nt + 6'd1;
      end
      if ($urandom_range(0, 1) == 1) disp($urandom_range(0, 31), $urandom_range(0, 6) != 0, nt);
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 9) < 6) begin
          pr = $urandom_range(0, 31);
          if ($urandom_range(0, 9) < 7 && m_pend[pr]) bcast(k, m_tag[pr]);
          else bcast(k, $urandom_range(0, 63));
        end
      end
      t0 = cdb_tag_rst[5:0];
      t1 = cdb_tag_rst[11:6];
      if (cdb_valid == 2'b11 && t0 == t1) cdb_valid[1] = 1'b0;
      raddr(0, $urandom_range(0, 31));
      raddr(1, $urandom_range(0, 31));

      exp_we = '0;
      exp_rd = '0;
      for (int r = 0; r < 32; r++) hit[r] = 1'b0;
      for (int k = 0; k < 2; k++) begin
        for (int r = 0; r < 32; r++) begin
          if (cdb_valid[k] && m_pend[r] && m_tag[r] == cdb_tag_rst[k*6 +: 6] && !exp_we[k]) begin
            exp_we[k]         = 1'b1;
            exp_rd[k*5 +: 5]  = 5'(r);
            hit[r]            = 1'b1;
          end
        end
      end
      exp_rv = '0;
      exp_rt = '0;
      for (int i = 0; i < 2; i++) begin
        a = int'(raddr_rst[i*5 +: 5]);
        exp_rt[i*6 +: 6] = m_tag[a];
`ifdef RST_CDB_BYPASS_EN
        exp_rv[i] = m_pend[a] && !hit[a];
`else
        exp_rv[i] = m_pend[a];
`endif
      end
      busy = 0;
      for (int r = 0; r < 32; r++) busy += int'(m_pend[r]);
      push("rnd_rvalid", 0, {30'd0, exp_rv});
      push("rnd_rtag", 6, {20'd0, exp_rt});
      push("rnd_wen", 3, {30'd0, exp_we});
      push("rnd_rd", 4, {22'd0, exp_rd});
      push("rnd_busy", 5, busy);
      cyc();

      if (flush_rst) begin
        for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
      end else begin
        for (int r = 0; r < 32; r++) if (hit[r]) m_pend[r] = 1'b0;
        if (wen0_rst && waddr0_rst != 5'd0) begin
          m_pend[waddr0_rst] = wdata0_rst[6];
          m_tag[waddr0_rst]  = wdata0_rst[5:0];
        end
      end
    end
  endtask

  initial begin
    bit byp;
`ifdef RST_CDB_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif
    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cdb_valid = 2'b11;
    raddr(0, 3);
    raddr(1, 1);
    push("rst_rvalid", 0, 0);
    push("rst_busy", 5, 0);
    push("rst_wen", 3, 0);
    push("rst_rd", 4, 0);
    cyc();
    rst = 1'b1;

    // Dispatch then lookup
    idle(); disp(3, 1, 5); raddr(0, 3);
    push("disp_pre_rvalid", 0, 0);
    cyc();
    idle(); raddr(0, 3);
    push("disp_rvalid", 0, 2'b01);
    push("disp_rtag", 1, 5);
    push("disp_busy", 5, 1);
    cyc();

    // Single-channel broadcast on ch1
    idle(); bcast(1, 5); raddr(0, 3);
    push("cdb1_wen", 3, 2'b10);
    push("cdb1_rd", 4, {22'd0, 5'd3, 5'd0});
    push("cdb1_rvalid", 0, byp ? 0 : 1);
    push("cdb1_busy", 5, 1);
    cyc();
    idle(); raddr(0, 3);
    push("cdb1_after_rvalid", 0, 0);
    push("cdb1_after_busy", 5, 0);
    cyc();

    // Two channels in one cycle
    idle(); disp(4, 1, 7); cyc();
    idle(); disp(9, 1, 8); cyc();
    idle(); bcast(0, 7); bcast(1, 8); raddr(0, 4); raddr(1, 9);
    push("dual_wen", 3, 2'b11);
    push("dual_rd", 4, {22'd0, 5'd9, 5'd4});
    push("dual_busy", 5, 2);
    push("dual_rvalid", 0, byp ? 0 : 3);
    cyc();
    idle(); raddr(0, 4); raddr(1, 9);
    push("dual_after_rvalid", 0, 0);
    push("dual_after_busy", 5, 0);
    cyc();

    // Redispatch during broadcast of the old tag
    idle(); disp(6, 1, 2); cyc();
    idle(); disp(6, 1, 11); bcast(0, 2); raddr(0, 6); raddr(1, 9);
    push("redisp_wen", 3, 2'b01);
    push("redisp_rd", 4, 6);
    push("redisp_rvalid", 0, byp ? 0 : 1);
    push("redisp_rtag_old", 1, 2);
    cyc();
    idle(); raddr(0, 6);
    push("redisp_rvalid_new", 0, 1);
    push("redisp_rtag_new", 1, 11);
    push("redisp_busy", 5, 1);
    cyc();
    idle(); bcast(0, 11);
    push("redisp_clear_wen", 3, 2'b01);
    push("redisp_clear_rd", 4, 6);
    cyc();

    // x0 guard and flush overriding a dispatch
    idle(); disp(1, 1, 20); cyc();
    idle(); disp(2, 1, 21); cyc();
    idle(); disp(0, 1, 3); raddr(0, 0); raddr(1, 1);
    push("x0_rvalid", 0, 2'b10);
    push("x0_busy", 5, 2);
    cyc();
    idle(); flush_rst = 1'b1; disp(5, 1, 30); raddr(0, 0); raddr(1, 2);
    push("x0_never_rvalid", 0, 2'b10);
    push("x0_rtag", 1, 0);
    push("x0_busy_hold", 5, 2);
    cyc();
    idle(); raddr(0, 5); raddr(1, 1);
    push("flush_rvalid", 0, 0);
    push("flush_busy", 5, 0);
    push("flush_tag_kept", 2, 20);
    cyc();

    // Explicit clear via pending=0
    idle(); disp(7, 1, 9); cyc();
    idle(); disp(7, 0, 9); raddr(0, 7);
    push("clr_pre_rvalid", 0, 1);
    push("clr_pre_busy", 5, 1);
    cyc();
    idle(); raddr(0, 7);
    push("clr_rvalid", 0, 0);
    push("clr_busy", 5, 0);
    cyc();

    // Stale tag after rename
    idle(); disp(8, 1, 12); cyc();
    idle(); disp(8, 1, 13); cyc();
    idle(); bcast(0, 12); raddr(0, 8);
    push("stale_wen", 3, 0);
    push("stale_rd", 4, 0);
    push("stale_rvalid", 0, 1);
    push("stale_rtag", 1, 13);
    cyc();
    idle(); bcast(0, 13);
    push("stale_clear_wen", 3, 2'b01);
    push("stale_clear_rd", 4, 8);
    cyc();

    // Duplicate tags: lowest register reported
    idle(); disp(11, 1, 40); cyc();
    idle(); disp(12, 1, 40); cyc();
    idle(); bcast(1, 40);
    push("lowest_wen", 3, 2'b10);
    push("lowest_rd", 4, {22'd0, 5'd11, 5'd0});
    cyc();
    idle(); flush_rst = 1'b1; cyc();

    // CDB outputs forced low while reset is asserted
    idle(); disp(10, 1, 14); cyc();
    idle(); rst = 1'b0; bcast(0, 14);
    push("rstmid_wen", 3, 0);
    push("rstmid_rd", 4, 0);
    cyc();
    rst = 1'b1;
    idle(); raddr(0, 10);
    push("rstmid_rvalid", 0, 0);
    push("rstmid_busy", 5, 0);
    cyc();

    random_phase(150);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
